// File: rtl/fft_bank_writer.sv
// Write side of the FFT frame buffer: reorders bit-reversed R2MDC pairs into two
// even/odd sample banks and hands completed frame slots to the IFFT bank reader.
module fft_bank_writer #(
  parameter  int N_LOG2 = 6,
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 10,
  localparam int P_W    = N_LOG2 - 1,
  localparam int S_W    = ADDR_W - N_LOG2 + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  input  logic              rd_release_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data0_o,
  output logic [DATA_W-1:0] wr_data1_o,
  output logic              frame_done_o,
  output logic [P_W-1:0]    cntr_pairs_o,
  output logic [S_W-1:0]    slot_ptr_o,
  output logic [S_W:0]      occupancy_o,
  output logic              release_err_o
);

  localparam logic [S_W:0] OCC_FULL = {1'b1, {S_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [P_W-1:0]    cntr_q, cntr_d;
  logic [S_W-1:0]    slot_q, slot_d;
  logic [S_W:0]      occ_q, occ_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              accept;
  logic              commit;

  // Pair p lands at natural indices bitrev(p,N) and +1, i.e. in-slot row bitrev(p,N-1).
  function automatic logic [P_W-1:0] bitrev(input logic [P_W-1:0] v);
    logic [P_W-1:0] r;
    for (int i = 0; i < P_W; i++) r[i] = v[P_W-1-i];
    return r;
  endfunction

  assign accept = in_valid_i && (state_q == WRITE);
  assign commit = (state_q == COMMIT);

  always_comb begin
    state_d   = state_q;
    cntr_d    = cntr_q;
    slot_d    = slot_q;
    occ_d     = occ_q;
    err_d     = err_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    data0_d   = data0_q;
    data1_d   = data1_q;

    // A commit and a release in the same cycle cancel out.
    unique case ({commit, rd_release_i})
      2'b10: if (occ_q != OCC_FULL) occ_d = occ_q + 1'b1;
      2'b01: begin
        if (occ_q == '0) err_d = 1'b1;
        else             occ_d = occ_q - 1'b1;
      end
      default: ;
    endcase

    if (commit) slot_d = slot_q + 1'b1;

    if (accept) begin
      wr_addr_d = {slot_q, bitrev(cntr_q)};
      data0_d   = in_a_i;
      data1_d   = in_b_i;
      cntr_d    = cntr_q + 1'b1;
    end

    unique case (state_q)
      IDLE:    if (occ_d != OCC_FULL) state_d = WRITE;
      WRITE:   if (accept && (&cntr_q)) state_d = COMMIT;
      COMMIT:  state_d = (occ_d != OCC_FULL) ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cntr_q    <= '0;
      slot_q    <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      slot_q    <= slot_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
    end
  end

  assign in_ready_o    = (state_q == WRITE);
  assign frame_done_o  = commit;
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data0_o    = data0_q;
  assign wr_data1_o    = data1_q;
  assign cntr_pairs_o  = cntr_q;
  assign slot_ptr_o    = slot_q;
  assign occupancy_o   = occ_q;
  assign release_err_o = err_q;

endmodule

// File: tb/tb_fft_bank_writer.sv
// Bench for fft_bank_writer: frame-level reference model checked every cycle,
// plus literal expectations at the interesting points of each directed scenario.
module tb_fft_bank_writer;

  logic        clk_i = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, rd_release_i;
  logic [31:0] in_a_i, in_b_i, wr_data0_o, wr_data1_o;
  logic        wr_en_o, frame_done_o, release_err_o;
  logic [9:0]  wr_addr_o;
  logic [4:0]  cntr_pairs_o, slot_ptr_o;
  logic [5:0]  occupancy_o;

  int errors = 0;
  int checks = 0;

  fft_bank_writer dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .rd_release_i(rd_release_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data0_o(wr_data0_o),
    .wr_data1_o(wr_data1_o), .frame_done_o(frame_done_o), .cntr_pairs_o(cntr_pairs_o),
    .slot_ptr_o(slot_ptr_o), .occupancy_o(occupancy_o), .release_err_o(release_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev5(input int p);
    int r = 0;
    int v = p;
    for (int i = 0; i < 5; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Reference model: frame bookkeeping in plain integers.
  bit m_on = 0;
  bit m_ready, m_commit, m_err, m_wen;
  int m_occ, m_slot, m_p, m_addr;
  logic [31:0] m_d0, m_d1;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_on = 1; m_ready = 0; m_commit = 0; m_err = 0; m_wen = 0;
      m_occ = 0; m_slot = 0; m_p = 0; m_addr = 0; m_d0 = 0; m_d1 = 0;
    end else if (m_on) begin
      bit acc, last;
      int occ_new;
      acc = in_valid_i && m_ready;
      occ_new = m_occ;
      if (m_commit && !rd_release_i) occ_new = m_occ + 1;
      else if (!m_commit && rd_release_i) begin
        if (m_occ == 0) m_err = 1;
        else occ_new = m_occ - 1;
      end
      m_wen = acc;
      if (acc) begin
        m_addr = m_slot * 32 + rev5(m_p);
        m_d0 = in_a_i;
        m_d1 = in_b_i;
      end
      if (m_commit) m_slot = (m_slot + 1) % 32;
      last = acc && (m_p == 31);
      if (acc) m_p = (m_p + 1) % 32;
      m_commit = last;
      m_occ = occ_new;
      m_ready = !last && (occ_new < 32);
    end
  end

  always @(negedge clk_i) begin
    if (m_on) begin
      chk("in_ready", in_ready_o, m_ready);
      chk("wr_en", wr_en_o, m_wen);
      chk("frame_done", frame_done_o, m_commit);
      chk("cntr_pairs", cntr_pairs_o, m_p);
      chk("slot_ptr", slot_ptr_o, m_slot);
      chk("occupancy", occupancy_o, m_occ);
      chk("release_err", release_err_o, m_err);
      if (m_wen) begin
        chk("wr_addr", wr_addr_o, m_addr);
        chk("wr_data0", wr_data0_o, m_d0);
        chk("wr_data1", wr_data1_o, m_d1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  int  cnt;
  bit  seen_3ff;
  bit  got_done;

  initial begin
    rst_i = 1; in_valid_i = 0; in_a_i = 0; in_b_i = 0; rd_release_i = 0;
    cyc(); cyc();
    chk("rst wr_addr", wr_addr_o, 10'h000);
    chk("rst in_ready", in_ready_o, 1'b0);
    rst_i = 0;
    cyc();
    chk("ready after idle", in_ready_o, 1'b1);

    // Frame 0: in_a=p, in_b=p+0x100
    for (int p = 0; p < 32; p++) begin
      in_valid_i = 1; in_a_i = p; in_b_i = p + 32'h100;
      cyc();
      if (p == 1) chk("p1 addr", wr_addr_o, 10'h010);
      if (p == 5) begin
        chk("p5 addr", wr_addr_o, 10'h014);
        chk("p5 d0", wr_data0_o, 32'h5);
        chk("p5 d1", wr_data1_o, 32'h105);
      end
      if (p == 31) begin
        chk("last addr", wr_addr_o, 10'h01F);
        chk("done with last wr", {frame_done_o, wr_en_o}, 2'b11);
      end
    end
    in_valid_i = 0;
    cyc();
    chk("f0 occupancy", occupancy_o, 6'd1);
    chk("f0 slot", slot_ptr_o, 5'd1);
    chk("f0 done gone", frame_done_o, 1'b0);

    // Release the only frame, then an illegal release at occupancy 0
    rd_release_i = 1; cyc();
    chk("occ after rel", occupancy_o, 6'd0);
    chk("no err yet", release_err_o, 1'b0);
    cyc();
    rd_release_i = 0;
    chk("err occ", occupancy_o, 6'd0);
    chk("err set", release_err_o, 1'b1);
    cyc(); cyc();
    chk("err sticky", release_err_o, 1'b1);

    // Reset, then fill all 32 slots without releases
    rst_i = 1; cyc();
    chk("err cleared", release_err_o, 1'b0);
    rst_i = 0; cyc();
    cnt = 0; seen_3ff = 0;
    for (int i = 0; i < 32 * 33 + 6; i++) begin
      in_valid_i = 1; in_a_i = cnt; in_b_i = ~cnt; cnt++;
      cyc();
      if (wr_en_o && wr_addr_o == 10'h3FF) seen_3ff = 1;
    end
    chk("addr 3ff written", seen_3ff, 1'b1);
    chk("full occ", occupancy_o, 6'd32);
    chk("full not ready", in_ready_o, 1'b0);
    chk("full slot wrapped", slot_ptr_o, 5'd0);

    rd_release_i = 1; in_valid_i = 0; cyc();
    rd_release_i = 0;
    chk("occ 31", occupancy_o, 6'd31);
    chk("ready again", in_ready_o, 1'b1);
    in_valid_i = 1; in_a_i = 32'h55; in_b_i = 32'hAA; cyc();
    chk("slot0 restart addr", wr_addr_o, 10'h000);

    // Release coinciding with the commit cycle
    got_done = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      in_a_i = cnt; in_b_i = cnt ^ 32'hF0F0; cnt++;
      cyc();
      if (frame_done_o) got_done = 1;
    end
    chk("commit reached", got_done, 1'b1);
    rd_release_i = 1; in_valid_i = 0; cyc();
    rd_release_i = 0;
    chk("commit+rel occ", occupancy_o, 6'd31);
    chk("commit+rel err", release_err_o, 1'b0);
    chk("commit+rel ready", in_ready_o, 1'b1);

    // Reset after beat p=17
    for (int p = 0; p < 18; p++) begin
      in_valid_i = 1; in_a_i = p; in_b_i = p; cyc();
    end
    chk("p17 cntr", cntr_pairs_o, 5'd18);
    rst_i = 1; in_valid_i = 0; cyc();
    chk("mid rst cntr", cntr_pairs_o, 5'd0);
    chk("mid rst occ", occupancy_o, 6'd0);
    chk("mid rst done", frame_done_o, 1'b0);
    chk("mid rst wr_en", wr_en_o, 1'b0);
    rst_i = 0; cyc();
    in_valid_i = 1; in_a_i = 32'hAB; in_b_i = 32'hCD; cyc();
    chk("restart addr", wr_addr_o, 10'h000);
    chk("restart d0", wr_data0_o, 32'hAB);
    in_valid_i = 0; cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
